// File: rtl/utils_pkg.sv
// Shared arbitration helpers: channel-count limit and one-hot to index conversion.
package utils_pkg;

  localparam int ARB_MAX_CH = 32;
  localparam int ARB_IDXW   = $clog2(ARB_MAX_CH);

  typedef logic [ARB_MAX_CH-1:0] arb_vec_t;
  typedef logic [ARB_IDXW-1:0]   arb_idx_t;

  function automatic arb_idx_t onehot2idx(input arb_vec_t onehot);
    arb_idx_t idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_CH; i++) begin
      if (onehot[i]) idx |= ARB_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_grant.sv
// One-hot grant generator. STREAM_ARB_MUX_RR_EN selects round-robin (with its own
// pointer register); otherwise fixed priority, lowest index wins, and no state exists.
module arb_grant #(
  parameter  int NUM_CH = 4,
  localparam int SELW   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

`ifdef STREAM_ARB_MUX_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] win_idx;
  logic            found;
  int              j;

  // Search starts at the pointer and wraps modulo NUM_CH; first requester found wins.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win_idx  = SELW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (win_idx == SELW'(NUM_CH-1)) ? '0 : win_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_rr;

  // Isolate the lowest set request bit.
  assign grant     = req & (~req + NUM_CH'(1));
  assign unused_rr = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/stream_arb_mux.sv
// NUM_CH-way valid/ready arbiter feeding one registered output stage; the winning
// channel index travels with the data. Arbitration policy set by STREAM_ARB_MUX_RR_EN.
module stream_arb_mux #(
  parameter  int DATAWIDTH = 32,
  parameter  int NUM_CH    = 4,
  localparam int SELW      = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        out_valid,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic [SELW-1:0]             out_sel,
  input  logic                        out_ready
);
  import utils_pkg::*;

  if (NUM_CH < 2 || NUM_CH > ARB_MAX_CH) begin : g_bad_cfg
    $error("stream_arb_mux: NUM_CH must be in 2..ARB_MAX_CH");
  end

  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]      out_sel_q,   out_sel_d;

  logic                 load_en;
  logic                 xfer;
  logic [NUM_CH-1:0]    grant;
  arb_vec_t             grant_ext;
  logic [SELW-1:0]      win_sel;
  logic [DATAWIDTH-1:0] win_data;

  arb_grant #(.NUM_CH(NUM_CH)) u_arb_grant (
    .clk     (clk),
    .reset   (reset),
    .req     (in_valid),
    .advance (xfer),
    .grant   (grant)
  );

  // Reset gates in_ready so no source sees an accept in the cycle its beat would be lost.
  assign load_en  = ~out_valid_q | out_ready;
  assign in_ready = (load_en && !reset) ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    grant_ext               = '0;
    grant_ext[NUM_CH-1:0]   = grant;
  end

  assign win_sel = SELW'(onehot2idx(grant_ext));

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win_data |= in_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // A load during drain replaces the beat; a drain alone keeps data/sel for debug visibility.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_sel_d   = win_sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: directed vectors push expected beats, a monitor
// pops and compares them as the output stage hands beats to the consumer.
module tb_stream_arb_mux;

  localparam int DW  = 32;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_sel;
  logic              out_ready;

  always #5 clk = ~clk;

  stream_arb_mux #(.DATAWIDTH(DW), .NUM_CH(NCH)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

`ifdef STREAM_ARB_MUX_RR_EN
  logic [2:0]    v3;
  logic [3*DW-1:0] d3;
  logic [2:0]    rdy3;
  logic          ov3;
  logic [DW-1:0] od3;
  logic [1:0]    os3;
  logic          ordy3;

  stream_arb_mux #(.DATAWIDTH(DW), .NUM_CH(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v3),
    .in_data   (d3),
    .in_ready  (rdy3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_ready (ordy3)
  );
`endif

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] d, input logic [1:0] s);
    chk({name, "_valid"}, 64'(out_valid), 64'(v));
    chk({name, "_data"},  64'(out_data),  64'(d));
    chk({name, "_sel"},   64'(out_sel),   64'(s));
  endtask

  // Drive one cycle of inputs just after the edge, check in_ready, and log the expected beat.
  task automatic step(input logic rst, input logic [3:0] v, input logic ordy,
                      input logic [127:0] d, input logic [3:0] exp_rdy, input string name);
    beat_t b;
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = v;
    out_ready = ordy;
    in_data   = d;
    #1;
    chk({name, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (!rst && exp_rdy != 4'b0000) begin
      b.sel = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) b.sel = 2'(i);
      b.data = d[int'(b.sel)*32 +: 32];
      sb_q.push_back(b);
    end
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got sel %0d data %h, expected no beat", out_sel, out_data);
        end else begin
          e = sb_q.pop_front();
          chk("beat_sel",  64'(out_sel),  64'(e.sel));
          chk("beat_data", 64'(out_data), 64'(e.data));
        end
      end
    end
  end

  localparam logic [127:0] D_MS  = {32'h0, 32'hA5A5_0002, 32'h0, 32'h0};
  localparam logic [127:0] D_ALL = {32'hCC00_0003, 32'hCC00_0002, 32'hCC00_0001, 32'hCC00_0000};
  localparam logic [127:0] D_BP  = {32'h3333_0003, 32'h0, 32'h0, 32'hDEAD_BEEF};

`ifdef STREAM_ARB_MUX_RR_EN
  logic [3:0] rr_v   [10];
  logic [3:0] rr_exp [10];
`endif

  initial begin : stim
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef STREAM_ARB_MUX_RR_EN
    v3    = '0;
    d3    = '0;
    ordy3 = 1'b1;
`endif
    repeat (2) @(posedge clk);

    // reset: requests present and consumer ready, yet nothing may be accepted
    step(1'b1, 4'b1111, 1'b1, D_ALL, 4'b0000, "rst_hold");
    chk_out("rst_state", 1'b0, 32'h0, 2'd0);

    // reset mid-stall
    step(1'b0, 4'b0100, 1'b0, D_MS, 4'b0100, "ms_load");
    step(1'b0, 4'b0100, 1'b0, D_MS, 4'b0000, "ms_stall");
    chk_out("ms_held", 1'b1, 32'hA5A5_0002, 2'd2);
    step(1'b1, 4'b0100, 1'b1, D_MS, 4'b0000, "ms_reset");
    sb_q.delete();
    step(1'b0, 4'b0000, 1'b1, '0, 4'b0000, "ms_after");
    chk_out("ms_cleared", 1'b0, 32'h0, 2'd0);

    // single channel, consumer always ready
    step(1'b0, 4'b0010, 1'b1, {64'h0, 32'h11, 32'h0}, 4'b0010, "sc_11");
    step(1'b0, 4'b0010, 1'b1, {64'h0, 32'h22, 32'h0}, 4'b0010, "sc_22");
    chk_out("sc_lat", 1'b1, 32'h11, 2'd1);
    step(1'b0, 4'b0010, 1'b1, {64'h0, 32'h33, 32'h0}, 4'b0010, "sc_33");
    chk_out("sc_b2b", 1'b1, 32'h22, 2'd1);
    step(1'b0, 4'b0000, 1'b1, '0, 4'b0000, "sc_idle");

    // backpressure: five stalled cycles, then drain and reload in the same cycle
    step(1'b0, 4'b0001, 1'b0, D_BP, 4'b0001, "bp_load");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1000, 1'b0, D_BP, 4'b0000, "bp_stall");
      chk_out("bp_hold", 1'b1, 32'hDEAD_BEEF, 2'd0);
    end
    step(1'b0, 4'b1000, 1'b1, D_BP, 4'b1000, "bp_swap");
    step(1'b0, 4'b0000, 1'b1, D_BP, 4'b0000, "bp_drain");
    chk_out("bp_swapped", 1'b1, 32'h3333_0003, 2'd3);
    step(1'b0, 4'b0000, 1'b0, D_BP, 4'b0000, "bp_idle");
    chk_out("bp_drained", 1'b0, 32'h3333_0003, 2'd3);

`ifndef STREAM_ARB_MUX_RR_EN
    // fixed priority: ch0 wins while asserted, then ch1
    repeat (4) step(1'b0, 4'b1111, 1'b1, D_ALL, 4'b0001, "fp_all");
    step(1'b0, 4'b1110, 1'b1, D_ALL, 4'b0010, "fp_upper");
    step(1'b0, 4'b0000, 1'b1, D_ALL, 4'b0000, "fp_idle");
`else
    // pointer is 0 here: reset, then ch1 x3 -> 2, ch0 -> 1, ch3 -> 0
    rr_v   = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
               4'b0101, 4'b0101, 4'b0101};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100,
               4'b0001, 4'b0100, 4'b0001};
    for (int i = 0; i < 10; i++) step(1'b0, rr_v[i], 1'b1, D_ALL, rr_exp[i], "rr_seq");
    step(1'b0, 4'b0000, 1'b1, D_ALL, 4'b0000, "rr_idle");

    // three channels: ch2 wins, pointer wraps to 0, ch0 then ch1
    @(posedge clk);
    #1;
    v3 = 3'b100;
    d3 = {32'h3300_0002, 32'h3300_0001, 32'h3300_0000};
    #1;
    chk("n3_rdy_ch2", 64'(rdy3), 64'(3'b100));
    @(posedge clk);
    #1;
    chk("n3_sel_2", 64'(os3), 64'd2);
    chk("n3_valid", 64'(ov3), 64'd1);
    v3 = 3'b011;
    #1;
    chk("n3_rdy_wrap", 64'(rdy3), 64'(3'b001));
    @(posedge clk);
    #1;
    chk("n3_sel_0", 64'(os3), 64'd0);
    chk("n3_data_0", 64'(od3), 64'h3300_0000);
    #1;
    chk("n3_rdy_next", 64'(rdy3), 64'(3'b010));
    v3 = 3'b000;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
